uart_rx_os: RTL and testbench

Oversampling UART receiver: the receiving end of the team's 8-bit UART link.
- Recovers frames from an asynchronous serial line using 16x oversampling and majority voting.
- Checks parity and stop-bit framing, and rejects glitches that look like a start bit.
- Sits beside uart_top as the standalone RX endpoint for external serial inputs, where line noise and baud mismatch must be tolerated.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_os_if.sv | 26 ++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_rx_os.sv | 150 +++++++++++++++
 tb/tb_uart_rx_os.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and divider helper
// Purpose: receiver state encoding, frame width and baud divider calculation
//          shared by the RX endpoint and the baud tick generator.
// Ports:   none (package).
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   // Clocks per oversample tick, rounded to nearest.
   function automatic int calc_div(input longint clk_freq,
                                   input longint baud_rate,
                                   input longint oversample);
      longint den;
      den = baud_rate * oversample;
      return int'((clk_freq + den / 2) / den);
   endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - serial line and received-frame signals of the RX endpoint
// Purpose: bundles the serial input and the frame result outputs.
// Ports:   rx (serial line, idles high), rx_data (last byte), rx_valid (frame pulse),
//          parity_error, framing_error (flags of last frame), rx_busy (frame in progress).
//          master = line driver / consumer side, slave = receiver side.
interface uart_rx_os_if;
   import uart_pkg::*;

   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 parity_error;
   logic                 framing_error;
   logic                 rx_busy;

   modport master (
      output rx,
      input  rx_data, rx_valid, parity_error, framing_error, rx_busy
   );

   modport slave (
      input  rx,
      output rx_data, rx_valid, parity_error, framing_error, rx_busy
   );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - divide-by-DIV oversample tick generator
// Purpose: pulses tick for one clk every DIV enabled clocks; clear restarts the
//          phase so the first tick comes DIV clocks after clear is released.
// Ports:   clk, reset (sync, active-high), clear (sync restart), enable (count),
//          tick (one-clk pulse).
module uart_baud_gen #(
   parameter int DIV = 326
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (enable) begin
         if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority voting
// Purpose: recovers 8-bit frames (start, data LSB first, optional parity, stop)
//          from an asynchronous line, flags parity and framing errors and
//          rejects start-bit glitches.
// Ports:   clk, reset (sync, active-high), bus (uart_rx_os_if.slave: rx in;
//          rx_data, rx_valid, parity_error, framing_error, rx_busy out).
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input logic         clk,
   input logic         reset,
   uart_rx_os_if.slave bus
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic          ODD    = (PARITY_ODD != 0);

   rx_state_t            state;
   logic                 rx_meta, rx_s, rx_s_d;
   logic [SW-1:0]        sample_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 smp_lo, smp_mid;
   logic                 par_err;
   logic                 high_seen;
   logic                 tick;
   logic                 maj, decide, bit_end;

   logic [DATA_BITS-1:0] rx_data_r;
   logic                 rx_valid_r, parity_error_r, framing_error_r, rx_busy_r;

   // Held in clear while idle so the first tick lands DIV clocks after the
   // detected falling edge.
   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == IDLE),
      .enable (state != IDLE),
      .tick   (tick)
   );

   always_comb begin
      maj     = (smp_lo & smp_mid) | (smp_lo & rx_s) | (smp_mid & rx_s);
      decide  = tick && (sample_cnt == S_HI);
      bit_end = tick && (sample_cnt == S_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         rx_meta         <= 1'b1;
         rx_s            <= 1'b1;
         rx_s_d          <= 1'b1;
         sample_cnt      <= '0;
         bit_cnt         <= '0;
         shreg           <= '0;
         smp_lo          <= 1'b1;
         smp_mid         <= 1'b1;
         par_err         <= 1'b0;
         high_seen       <= 1'b0;
         rx_data_r       <= '0;
         rx_valid_r      <= 1'b0;
         parity_error_r  <= 1'b0;
         framing_error_r <= 1'b0;
         rx_busy_r       <= 1'b0;
      end else begin
         rx_meta    <= bus.rx;
         rx_s       <= rx_meta;
         rx_s_d     <= rx_s;
         rx_valid_r <= 1'b0;

         // sample_cnt names the sample the next tick will take.
         if (tick) begin
            sample_cnt <= (sample_cnt == S_LAST) ? '0 : sample_cnt + 1'b1;
            if (sample_cnt == S_LO)  smp_lo  <= rx_s;
            if (sample_cnt == S_MID) smp_mid <= rx_s;
         end

         case (state)
            IDLE: begin
               sample_cnt <= '0;
               if (rx_s_d && !rx_s) state <= START;
            end
            START: begin
               if (decide) begin
                  if (maj) state     <= IDLE;
                  else     rx_busy_r <= 1'b1;
               end else if (bit_end) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bit_cnt == BW'(DATA_BITS - 1))
                     state <= (PARITY_EN != 0) ? PARITY : STOP;
                  else
                     bit_cnt <= bit_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (decide) par_err <= (maj != ((^shreg) ^ ODD));
               if (bit_end) state <= STOP;
            end
            STOP: begin
               if (decide) begin
                  rx_data_r       <= shreg;
                  parity_error_r  <= (PARITY_EN != 0) && par_err;
                  framing_error_r <= !maj;
                  rx_valid_r      <= 1'b1;
                  rx_busy_r       <= 1'b0;
                  high_seen       <= 1'b0;
                  state           <= maj ? IDLE : WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               // Leave only after the line stayed high across a whole tick period.
               if (!rx_s) begin
                  high_seen <= 1'b0;
               end else if (tick) begin
                  if (high_seen) state <= IDLE;
                  high_seen <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rx_data       = rx_data_r;
   assign bus.rx_valid      = rx_valid_r;
   assign bus.parity_error  = parity_error_r;
   assign bus.framing_error = framing_error_r;
   assign bus.rx_busy       = rx_busy_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard bench for the oversampling UART receiver
`timescale 1ns/1ps
module tb_uart_rx_os;

   localparam int      CLK_FREQ = 50_000_000;
   localparam int      BAUD     = 195_312;
   localparam int      OS       = 16;
   localparam int      PEN      = 1;
   localparam int      PODD     = 0;
   localparam int      DIV      = 16;
   localparam int      BIT_CLK  = OS * DIV;
   localparam realtime BIT_NS   = 5120.0;
   localparam int      LAT      = 2 + DIV * (OS * (9 + PEN) + OS / 2 + 2) + 1;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #10 clk = ~clk;

   uart_rx_os_if bus();

   uart_rx_os #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD),
      .OVERSAMPLE (OS),
      .PARITY_EN  (PEN),
      .PARITY_ODD (PODD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   valid_cnt = 0;
   int   ign_cnt = 0;
   int   last_valid_cyc = 0;
   bit   ignore = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_valid) begin
         valid_cnt++;
         last_valid_cyc = cyc;
         if (ignore) begin
            ign_cnt++;
         end else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: rx_data=%h arrived, required no frame", bus.rx_data);
         end else begin
            mon_e = q.pop_front();
            checks++;
            if (bus.rx_data !== mon_e.data) begin
               errors++;
               $display("FAIL rx_data: got %h, required %h", bus.rx_data, mon_e.data);
            end
            checks++;
            if (bus.parity_error !== mon_e.perr) begin
               errors++;
               $display("FAIL parity_error: got %b, required %b (data %h)", bus.parity_error, mon_e.perr, mon_e.data);
            end
            checks++;
            if (bus.framing_error !== mon_e.ferr) begin
               errors++;
               $display("FAIL framing_error: got %b, required %b (data %h)", bus.framing_error, mon_e.ferr, mon_e.data);
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_v, input realtime bt);
      logic podd_bit;
      podd_bit = (PODD != 0);
      bus.rx = 1'b0;
      #(bt);
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         #(bt);
      end
      if (PEN != 0) begin
         bus.rx = (^d) ^ podd_bit ^ flip;
         #(bt);
      end
      bus.rx = stop_v;
      #(bt);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d frames pending after %0d clk, required 0", name, q.size(), budget);
         q.delete();
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if (bus.rx_data !== 8'h00) begin
         errors++;
         $display("FAIL %s_rx_data: got %h, required 00", name, bus.rx_data);
      end
      checks++;
      if (bus.rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_rx_valid: got %b, required 0", name, bus.rx_valid);
      end
      checks++;
      if (bus.parity_error !== 1'b0) begin
         errors++;
         $display("FAIL %s_parity_error: got %b, required 0", name, bus.parity_error);
      end
      checks++;
      if (bus.framing_error !== 1'b0) begin
         errors++;
         $display("FAIL %s_framing_error: got %b, required 0", name, bus.framing_error);
      end
      checks++;
      if (bus.rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_rx_busy: got %b, required 0", name, bus.rx_busy);
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      bus.rx = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset = 1'b0;
      repeat (BIT_CLK) @(posedge clk);
   endtask

   task automatic test_basic();
      int fall_cyc, v0, lat;
      q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
      v0 = valid_cnt;
      @(posedge clk);
      #1;
      fall_cyc = cyc;
      fork
         send_frame(8'hA5, 1'b0, 1'b1, BIT_NS);
         begin
            #(4.5 * BIT_NS);
            checks++;
            if (bus.rx_busy !== 1'b1) begin
               errors++;
               $display("FAIL basic_busy_mid: rx_busy=%b, required 1", bus.rx_busy);
            end
         end
      join
      wait_drain("basic_a5", 2 * BIT_CLK);
      lat = last_valid_cyc - fall_cyc;
      checks++;
      if (lat < LAT - 2 || lat > LAT + 2) begin
         errors++;
         $display("FAIL basic_latency: got %0d clk, required %0d +/-2", lat, LAT);
      end
      checks++;
      if (bus.rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_after: rx_busy=%b, required 0", bus.rx_busy);
      end
      checks++;
      if (valid_cnt - v0 != 1) begin
         errors++;
         $display("FAIL basic_valid_count: got %0d, required 1", valid_cnt - v0);
      end
   endtask

   task automatic test_parity();
      q.push_back('{data: 8'h3C, perr: 1'b1, ferr: 1'b0});
      send_frame(8'h3C, 1'b1, 1'b1, BIT_NS);
      #(BIT_NS);
      q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
      send_frame(8'h3C, 1'b0, 1'b1, BIT_NS);
      #(BIT_NS);
      wait_drain("parity", 2 * BIT_CLK);
   endtask

   task automatic test_framing();
      int v0;
      v0 = valid_cnt;
      q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1});
      send_frame(8'h55, 1'b0, 1'b0, BIT_NS);
      #(3 * BIT_NS);
      bus.rx = 1'b1;
      #(2 * BIT_NS);
      wait_drain("framing_55", 2 * BIT_CLK);
      checks++;
      if (valid_cnt - v0 != 1) begin
         errors++;
         $display("FAIL framing_valid_count: got %0d, required 1", valid_cnt - v0);
      end
      q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0});
      send_frame(8'h81, 1'b0, 1'b1, BIT_NS);
      #(BIT_NS);
      wait_drain("framing_81", 2 * BIT_CLK);
   endtask

   task automatic test_glitch();
      int v0;
      v0 = valid_cnt;
      @(posedge clk);
      #1;
      bus.rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.rx = 1'b1;
      repeat (9 * DIV - 3) @(posedge clk);
      #1;
      checks++;
      if (bus.rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy: rx_busy=%b before sample 9, required 0", bus.rx_busy);
      end
      #(12 * BIT_NS);
      checks++;
      if (valid_cnt != v0) begin
         errors++;
         $display("FAIL glitch_valid_count: got %0d, required 0", valid_cnt - v0);
      end
   endtask

   task automatic test_back_to_back(input string name, input real rate);
      realtime bt;
      int v0;
      bt = BIT_NS / rate;
      v0 = valid_cnt;
      q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b0});
      q.push_back('{data: 8'hFF, perr: 1'b0, ferr: 1'b0});
      q.push_back('{data: 8'h96, perr: 1'b0, ferr: 1'b0});
      send_frame(8'h00, 1'b0, 1'b1, bt);
      send_frame(8'hFF, 1'b0, 1'b1, bt);
      send_frame(8'h96, 1'b0, 1'b1, bt);
      bus.rx = 1'b1;
      #(2 * BIT_NS);
      wait_drain(name, 2 * BIT_CLK);
      checks++;
      if (valid_cnt - v0 != 3) begin
         errors++;
         $display("FAIL %s_valid_count: got %0d, required 3", name, valid_cnt - v0);
      end
   endtask

   task automatic test_reset_mid_frame();
      ignore  = 1'b1;
      ign_cnt = 0;
      fork
         send_frame(8'h77, 1'b0, 1'b1, BIT_NS);
         begin
            #(5.5 * BIT_NS);
            @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check_outputs_zero("midreset");
         end
      join
      #(BIT_NS);
      checks++;
      if (ign_cnt != 0) begin
         errors++;
         $display("FAIL midreset_no_valid: got %0d rx_valid for aborted frame, required 0", ign_cnt);
      end
      // The line fragment after the reset may resynchronise on a later edge;
      // let it settle before checking the next clean frame.
      #(10 * BIT_NS);
      ignore = 1'b0;
      q.push_back('{data: 8'h12, perr: 1'b0, ferr: 1'b0});
      send_frame(8'h12, 1'b0, 1'b1, BIT_NS);
      #(BIT_NS);
      wait_drain("after_reset_12", 2 * BIT_CLK);
   endtask

   initial begin
      bus.rx = 1'b1;
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_glitch();
      test_back_to_back("b2b_fast", 1.03);
      test_back_to_back("b2b_slow", 0.97);
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
